// File: rtl/mips_harvard_mem_sim.sv
// -----------------------------------------------------------------------------
// mips_harvard_mem_sim
// Simulation memory subsystem for the Harvard MIPS CPU benches.
//   - Instruction ROM with a combinational read port.
//   - Byte-enabled data RAM with a combinational read port.
//   - A data-side wait-state FSM that stalls the CPU through clk_enable.
//   - A sticky err flag for out-of-range, misaligned or conflicting accesses.
// Ports:
//   clk, reset           : single rising-edge clock, synchronous active-high reset
//   instr_address/readdata : fetch byte address / fetched word
//   data_address, data_read, data_write, data_byteenable, data_writedata
//                        : data request (held stable by the CPU while stalled)
//   data_readdata        : load data
//   clk_enable           : CPU advance enable (0 while a data access is stalled)
//   err                  : sticky access error, cleared only by reset
// Optional feature macro: MEM_SIM_TRACE_EN prints committed data accesses and
// the cause of the first error. Logic behaviour does not depend on it.
// -----------------------------------------------------------------------------
module mips_harvard_mem_sim #(
   parameter logic [31:0] ROM_BASE       = 32'hBFC00000,
   parameter int          ROM_WORDS_LOG2 = 8,
   parameter logic [31:0] RAM_BASE       = 32'h00000000,
   parameter int          RAM_WORDS_LOG2 = 8,
   parameter int          DATA_WAIT      = 0,
   parameter string       ROM_INIT_FILE  = "",
   parameter string       RAM_INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_byteenable,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic        clk_enable,
   output logic        err
);

   localparam int          ROM_DEPTH = 1 << ROM_WORDS_LOG2;
   localparam int          RAM_DEPTH = 1 << RAM_WORDS_LOG2;
   localparam logic [32:0] ROM_BYTES = 33'd4 << ROM_WORDS_LOG2;
   localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_WORDS_LOG2;
   localparam logic [3:0]  WAIT_LOAD = (DATA_WAIT > 0) ? 4'(DATA_WAIT - 1) : 4'd0;

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   logic [31:0] rom [0:ROM_DEPTH-1];
   logic [31:0] ram [0:RAM_DEPTH-1];

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        err_r;

   logic [31:0] rom_off_s;
   logic [31:0] ram_off_s;
   logic        rom_ok_s;
   logic        ram_in_s;
   logic        ram_ok_s;
   logic        access_s;
   logic        conflict_s;
   logic        fetch_bad_s;
   logic        data_bad_s;
   logic        err_set_s;
   logic        commit_s;

   // Memory contents exist from time 0: zero-fill.
   initial begin
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 32'd0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] = 32'd0;
   end

   // Address decode, error detection and combinational read ports.
   always_comb begin
      // Unsigned 32-bit offsets: addresses below BASE wrap and fall out of range.
      rom_off_s  = instr_address - ROM_BASE;
      ram_off_s  = data_address - RAM_BASE;
      rom_ok_s   = ({1'b0, rom_off_s} < ROM_BYTES) && (instr_address[1:0] == 2'b00);
      ram_in_s   = ({1'b0, ram_off_s} < RAM_BYTES);
      ram_ok_s   = ram_in_s && (data_address[1:0] == 2'b00);
      access_s   = data_read | data_write;
      conflict_s = data_read & data_write;
      // Address 0 is the CPU halt address and is fetched legitimately.
      fetch_bad_s = !rom_ok_s && (instr_address != 32'd0);
      data_bad_s  = access_s && !ram_ok_s;
      err_set_s   = fetch_bad_s | data_bad_s | conflict_s;
      commit_s    = clk_enable && !reset && data_write && !data_read && ram_ok_s;

      if (rom_ok_s) begin
         instr_readdata = rom[rom_off_s[ROM_WORDS_LOG2+1:2]];
      end else begin
         instr_readdata = 32'd0;
      end

      if (data_read && ram_ok_s) begin
         data_readdata = ram[ram_off_s[RAM_WORDS_LOG2+1:2]];
      end else begin
         data_readdata = 32'd0;
      end
   end

   // clk_enable drops in the same cycle an access is seen so the CPU holds it.
   always_comb begin
      clk_enable = 1'b1;
      if (reset) begin
         clk_enable = 1'b1;
      end else begin
         case (state_r)
            IDLE:    clk_enable = !(access_s && (DATA_WAIT > 0));
            WAIT:    clk_enable = (cnt_r == 4'd0);
            default: clk_enable = 1'b1;
         endcase
      end
   end

   // Wait-state FSM and sticky error register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (access_s && (DATA_WAIT > 0)) begin
                  state_r <= WAIT;
                  cnt_r   <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
         if (clk_enable && err_set_s) begin
            err_r <= 1'b1;
         end
      end
   end

   // Byte-lane store commit; memory contents are never touched by reset.
   always @(posedge clk) begin
      if (commit_s) begin
         for (int i = 0; i < 4; i++) begin
            if (data_byteenable[i]) begin
               ram[ram_off_s[RAM_WORDS_LOG2+1:2]][8*i +: 8] <= data_writedata[8*i +: 8];
            end
         end
      end
   end

   assign err = err_r;

`ifdef MEM_SIM_TRACE_EN
   // Access trace: one line per committed data access and one at first error.
   always @(posedge clk) begin
      if (!reset && clk_enable) begin
         if (commit_s) begin
            $display("%0t mem_sim W addr=%h data=%h be=%b", $time, data_address,
                     data_writedata, data_byteenable);
         end else if (data_read && !data_write && ram_ok_s) begin
            $display("%0t mem_sim R addr=%h data=%h be=%b", $time, data_address,
                     data_readdata, data_byteenable);
         end
         if (!err_r && err_set_s) begin
            if (conflict_s) begin
               $display("%0t mem_sim err cause=conflict", $time);
            end else if ((fetch_bad_s && (instr_address[1:0] != 2'b00)) ||
                         (data_bad_s && ram_in_s)) begin
               $display("%0t mem_sim err cause=align", $time);
            end else begin
               $display("%0t mem_sim err cause=range", $time);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mips_harvard_mem_sim.sv
// -----------------------------------------------------------------------------
// Bench for mips_harvard_mem_sim. Two instances: u_dut0 (no wait states) is
// driven from a vector table, u_dut3 (three wait states) by hand-written
// sequences covering stalls, reset mid-stall and error stickiness.
// -----------------------------------------------------------------------------
module tb_mips_harvard_mem_sim;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance with DATA_WAIT = 0.
   logic        r0 = 1'b1;
   logic [31:0] ia0 = 32'd0, da0 = 32'd0, dw0 = 32'd0;
   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [3:0]  be0 = 4'd0;
   logic [31:0] ir0, dr0;
   logic        ce0, err0;

   // Instance with DATA_WAIT = 3.
   logic        r3 = 1'b1;
   logic [31:0] ia3 = 32'd0, da3 = 32'd0, dw3 = 32'd0;
   logic        rd3 = 1'b0, wr3 = 1'b0;
   logic [3:0]  be3 = 4'd0;
   logic [31:0] ir3, dr3;
   logic        ce3, err3;

   mips_harvard_mem_sim #(.DATA_WAIT(0)) u_dut0 (
      .clk(clk), .reset(r0), .instr_address(ia0), .instr_readdata(ir0),
      .data_address(da0), .data_read(rd0), .data_write(wr0),
      .data_byteenable(be0), .data_writedata(dw0), .data_readdata(dr0),
      .clk_enable(ce0), .err(err0));

   mips_harvard_mem_sim #(.DATA_WAIT(3)) u_dut3 (
      .clk(clk), .reset(r3), .instr_address(ia3), .instr_readdata(ir3),
      .data_address(da3), .data_read(rd3), .data_write(wr3),
      .data_byteenable(be3), .data_writedata(dw3), .data_readdata(dr3),
      .clk_enable(ce3), .err(err3));

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        ce;
      logic        err;
   } exp_t;

   vec_t vecs [12];
   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one data access on u_dut3 to completion; inputs are driven just after
   // a rising edge. Returns the number of stall cycles and the read data seen
   // in the first cycle of the access.
   task automatic access3(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          output int low, output logic [31:0] first_rdata);
      bit done = 1'b0;
      rd3 = rd; wr3 = wr; da3 = addr; be3 = be; dw3 = wdata;
      low = 0;
      first_rdata = 32'd0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (k == 0) first_rdata = dr3;
         if (ce3) begin
            done = 1'b1;
         end else begin
            low++;
         end
         step();
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL access3_timeout: clk_enable stuck at 0, expected 1 within 20 cycles");
      end
      rd3 = 1'b0; wr3 = 1'b0; be3 = 4'd0;
   endtask

   initial begin
      int          low;
      logic [31:0] rdv;
      exp_t        e;

      // Vector table for the zero-wait instance; each row is one cycle.
      vecs[0]  = '{1'b0, 1'b1, 32'h4,    4'hF,    32'h12345678, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h4,    4'h0,    32'h0,        32'h12345678, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'hC,    4'hF,    32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'hC,    4'b0010, 32'h0000AB00, 32'h0,        1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'hC,    4'h0,    32'h0,        32'h1122AB44, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h14,   4'b0000, 32'hAABBCCDD, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h14,   4'h0,    32'h0,        32'h0,        1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'h18,   4'b1001, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h18,   4'h0,    32'h0,        32'hFF0000FF, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h1000, 4'h0,    32'h0,        32'h0,        1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h0,    4'h0,    32'h0,        32'h0,        1'b1};
      vecs[11] = '{1'b1, 1'b0, 32'h4,    4'h0,    32'h0,        32'h12345678, 1'b1};

      #1;
      u_dut3.rom[1] = 32'hA5A50001;

      // Reset both instances for two cycles.
      step();
      step();
      r0 = 1'b0;
      r3 = 1'b0;
      @(negedge clk);
      check("reset_ce3",  32'(ce3),  32'd1);
      check("reset_err3", 32'(err3), 32'd0);
      check("reset_err0", 32'(err0), 32'd0);
      step();

      // Table-driven run on the zero-wait instance through the scoreboard.
      for (int i = 0; i < 12; i++) begin
         rd0 = vecs[i].rd; wr0 = vecs[i].wr; da0 = vecs[i].addr;
         be0 = vecs[i].be; dw0 = vecs[i].wdata;
         sb.push_back('{vecs[i].exp_rdata, 1'b1, vecs[i].exp_err});
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("vec%0d_rdata", i), dr0, e.rdata);
         check($sformatf("vec%0d_ce", i), 32'(ce0), 32'(e.ce));
         check($sformatf("vec%0d_err", i), 32'(err0), 32'(e.err));
         step();
      end
      rd0 = 1'b0; wr0 = 1'b0;

      // Fetches: ROM word 1, then the halt address without error.
      ia3 = 32'hBFC00004;
      @(negedge clk);
      check("fetch_rom1", ir3, 32'hA5A50001);
      step();
      ia3 = 32'h0;
      @(negedge clk);
      check("fetch_halt_data", ir3, 32'h0);
      step();
      @(negedge clk);
      check("fetch_halt_err", 32'(err3), 32'd0);
      step();

      // Full-word store with three wait states, then read it back.
      access3(1'b0, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF, low, rdv);
      check("store_stall_cycles", 32'(low), 32'd3);
      access3(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, low, rdv);
      check("load_8_data", rdv, 32'hDEADBEEF);
      check("load_stall_cycles", 32'(low), 32'd3);

      // Store aborted by reset in the second stall cycle.
      rd3 = 1'b0; wr3 = 1'b1; da3 = 32'h10; be3 = 4'hF; dw3 = 32'hCAFEF00D;
      @(negedge clk);
      check("abort_stall1_ce", 32'(ce3), 32'd0);
      step();
      @(negedge clk);
      check("abort_stall2_ce", 32'(ce3), 32'd0);
      r3 = 1'b1;
      step();
      r3 = 1'b0; wr3 = 1'b0; be3 = 4'd0;
      @(negedge clk);
      check("abort_idle_ce", 32'(ce3), 32'd1);
      step();
      access3(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, low, rdv);
      check("abort_ram4_unchanged", rdv, 32'h0);
      check("abort_then_full_stall", 32'(low), 32'd3);

      // Read and write together: error, no write.
      access3(1'b1, 1'b1, 32'h8, 4'hF, 32'h00000000, low, rdv);
      @(negedge clk);
      check("conflict_err", 32'(err3), 32'd1);
      step();
      access3(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, low, rdv);
      check("conflict_no_write", rdv, 32'hDEADBEEF);
      @(negedge clk);
      check("conflict_err_sticky", 32'(err3), 32'd1);

      // Reset clears err; a misaligned fetch sets it again.
      r3 = 1'b1;
      step();
      r3 = 1'b0;
      @(negedge clk);
      check("err_cleared", 32'(err3), 32'd0);
      step();
      ia3 = 32'hBFC00002;
      @(negedge clk);
      check("fetch_misaligned_data", ir3, 32'h0);
      step();
      ia3 = 32'h0;
      @(negedge clk);
      check("fetch_misaligned_err", 32'(err3), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
